// File: rtl/bram_read_scheduler_pkg.sv
// Shared definitions for the parameter-BRAM read scheduler.
// Holds the scheduler state encoding, the BRAM geometry and read latency
// defaults, and the base addresses of the weight/bias regions inside the
// parameter BRAM.
package bram_read_scheduler_pkg;

    localparam int BRAM_ADDR_WIDTH = 15;
    localparam int BRAM_W          = 8;
    localparam int RD_LAT_DEF      = 2;

    // Region base addresses inside the parameter BRAM.
    localparam int L1_WEIGHT_BASE  = 0;
    localparam int L12_BIAS_BASE   = 16392;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } sched_state_t;

endpackage

// File: rtl/bram_read_scheduler_if.sv
// Bundle of all scheduler-facing signals: requester side, BRAM read port and
// tagged read-data return.
//
// Request protocol: a requester raises req[i] (level) together with its
// req_base/req_len slices and holds it until done[i] pulses. grant[i] is high
// for the entire burst, including the drain of the BRAM latency; done[i] is a
// single-cycle pulse in the cycle grant[i] falls. There is no backpressure on
// the return path: a beat is delivered in every cycle rd_valid is high and
// every loader captures only beats whose rd_id matches its own index.
//
// Modports: master = scheduler, slave = requesters + BRAM.
interface bram_read_scheduler_if
    import bram_read_scheduler_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH,
    parameter int W          = BRAM_W,
    parameter int LEN_W      = 11,
    parameter int ID_W       = $clog2(N_REQ)
);
    logic [N_REQ-1:0]            req;
    logic [N_REQ*ADDR_WIDTH-1:0] req_base;
    logic [N_REQ*LEN_W-1:0]      req_len;
    logic [N_REQ-1:0]            grant;
    logic [N_REQ-1:0]            done;
    logic                        busy;
    logic                        bram_en;
    logic                        bram_ren;
    logic [ADDR_WIDTH-1:0]       bram_addr;
    logic [W-1:0]                bram_dout;
    logic                        rd_valid;
    logic [W-1:0]                rd_data;
    logic [ID_W-1:0]             rd_id;
    logic [LEN_W-1:0]            rd_idx;
    sched_state_t                dbg_state;

    modport master (
        input  req, req_base, req_len, bram_dout,
        output grant, done, busy, bram_en, bram_ren, bram_addr,
               rd_valid, rd_data, rd_id, rd_idx, dbg_state
    );

    modport slave (
        output req, req_base, req_len, bram_dout,
        input  grant, done, busy, bram_en, bram_ren, bram_addr,
               rd_valid, rd_data, rd_id, rd_idx, dbg_state
    );

endinterface

// File: rtl/bram_read_scheduler_rr_arbiter.sv
// Combinational round-robin pick.
// Ports: req (request vector), ptr (highest-priority index) -> gnt (one-hot
// winner), gnt_id (winner index), any (at least one request present).
// The search starts at ptr and wraps modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             any
);
    logic [ID_W-1:0] j;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        j      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = ID_W'((int'(ptr) + i) % N_REQ);
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                gnt_id = j;
            end
        end
    end

endmodule

// File: rtl/bram_read_scheduler.sv
// Shares the single parameter-BRAM read port between N_REQ burst loaders.
// Ports: clk, rst (sync, active high) and the scheduler bus (master modport):
// req/req_base/req_len in, grant/done/busy out, BRAM en/ren/addr out with
// bram_dout in, and the tagged return rd_valid/rd_data/rd_id/rd_idx plus the
// FSM state on dbg_state.
// A granted burst issues one address per cycle; each beat returns on rd_*
// RD_LAT+1 cycles after its address (RD_LAT BRAM cycles plus one output
// register). done pulses the cycle after the last beat is presented.
module bram_read_scheduler
    import bram_read_scheduler_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH,
    parameter int W          = BRAM_W,
    parameter int LEN_W      = 11,
    parameter int RD_LAT     = RD_LAT_DEF,
    parameter int ID_W       = $clog2(N_REQ)
) (
    input logic                   clk,
    input logic                   rst,
    bram_read_scheduler_if.master bus
);
    sched_state_t          state, state_n;
    logic [ID_W-1:0]       ptr, ptr_n, win_id, win_n;
    logic [ADDR_WIDTH-1:0] base_r, base_n, addr_r, addr_n;
    logic [LEN_W-1:0]      len_r, len_n, k_r, k_n, iss_idx, iss_idx_n;
    logic [N_REQ-1:0]      grant_r, grant_n, done_r, done_n;
    logic                  busy_r, busy_n, en_r, en_n, ren_r, ren_n;

    logic [N_REQ-1:0]      arb_gnt;
    logic [ID_W-1:0]       arb_id;
    logic                  arb_any;

    // Delay line tracking issued addresses through the BRAM latency.
    logic [RD_LAT-1:0]     dl_v;
    logic [LEN_W-1:0]      dl_idx [RD_LAT];
    logic [ID_W-1:0]       dl_id  [RD_LAT];

    logic                  rd_valid_r;
    logic [W-1:0]          rd_data_r;
    logic [LEN_W-1:0]      rd_idx_r;
    logic [ID_W-1:0]       rd_id_r;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req    (bus.req),
        .ptr    (ptr),
        .gnt    (arb_gnt),
        .gnt_id (arb_id),
        .any    (arb_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            win_id  <= '0;
            base_r  <= '0;
            len_r   <= '0;
            k_r     <= '0;
            iss_idx <= '0;
            addr_r  <= '0;
            grant_r <= '0;
            done_r  <= '0;
            busy_r  <= 1'b0;
            en_r    <= 1'b0;
            ren_r   <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            win_id  <= win_n;
            base_r  <= base_n;
            len_r   <= len_n;
            k_r     <= k_n;
            iss_idx <= iss_idx_n;
            addr_r  <= addr_n;
            grant_r <= grant_n;
            done_r  <= done_n;
            busy_r  <= busy_n;
            en_r    <= en_n;
            ren_r   <= ren_n;
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        win_n     = win_id;
        base_n    = base_r;
        len_n     = len_r;
        k_n       = k_r;
        iss_idx_n = iss_idx;
        addr_n    = addr_r;
        grant_n   = grant_r;
        done_n    = '0;
        busy_n    = busy_r;
        en_n      = en_r;
        ren_n     = 1'b0;
        case (state)
            S_IDLE: begin
                // Skip the done cycle: the finishing requester still shows req.
                if (arb_any && done_r == '0) begin
                    win_n   = arb_id;
                    base_n  = bus.req_base[arb_id*ADDR_WIDTH +: ADDR_WIDTH];
                    len_n   = bus.req_len[arb_id*LEN_W +: LEN_W];
                    grant_n = arb_gnt;
                    busy_n  = 1'b1;
                    k_n     = '0;
                    ptr_n   = ID_W'((int'(arb_id) + 1) % N_REQ);
                    state_n = (bus.req_len[arb_id*LEN_W +: LEN_W] == '0) ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                en_n      = 1'b1;
                ren_n     = 1'b1;
                addr_n    = base_r + ADDR_WIDTH'(k_r);  // wraps modulo 2^ADDR_WIDTH
                iss_idx_n = k_r;
                k_n       = k_r + LEN_W'(1);
                if (k_r == len_r - LEN_W'(1)) state_n = S_DRAIN;
            end
            S_DRAIN: begin
                // Empty pipe: the last beat is on rd_* this cycle (or none existed).
                if (!ren_r && dl_v == '0) begin
                    done_n  = grant_r;
                    grant_n = '0;
                    busy_n  = 1'b0;
                    en_n    = 1'b0;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dl_v       <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dl_idx[i] <= '0;
                dl_id[i]  <= '0;
            end
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
            rd_idx_r   <= '0;
            rd_id_r    <= '0;
        end else begin
            dl_v[0]   <= ren_r;
            dl_idx[0] <= iss_idx;
            dl_id[0]  <= win_id;
            for (int i = 1; i < RD_LAT; i++) begin
                dl_v[i]   <= dl_v[i-1];
                dl_idx[i] <= dl_idx[i-1];
                dl_id[i]  <= dl_id[i-1];
            end
            rd_valid_r <= dl_v[RD_LAT-1];
            if (dl_v[RD_LAT-1]) begin
                rd_data_r <= bus.bram_dout;
                rd_idx_r  <= dl_idx[RD_LAT-1];
                rd_id_r   <= dl_id[RD_LAT-1];
            end
        end
    end

    assign bus.grant     = grant_r;
    assign bus.done      = done_r;
    assign bus.busy      = busy_r;
    assign bus.bram_en   = en_r;
    assign bus.bram_ren  = ren_r;
    assign bus.bram_addr = addr_r;
    assign bus.rd_valid  = rd_valid_r;
    assign bus.rd_data   = rd_data_r;
    assign bus.rd_id     = rd_id_r;
    assign bus.rd_idx    = rd_idx_r;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_bram_read_scheduler.sv
// Directed bench for bram_read_scheduler with a BRAM model and a scoreboard
// of expected grants, addresses, beats and done timing.
module tb_bram_read_scheduler;
    import bram_read_scheduler_pkg::*;

    localparam int N_REQ      = 4;
    localparam int ADDR_WIDTH = BRAM_ADDR_WIDTH;
    localparam int W          = BRAM_W;
    localparam int LEN_W      = 11;
    localparam int RD_LAT     = RD_LAT_DEF;
    localparam int ID_W       = $clog2(N_REQ);
    localparam int BW         = ID_W + LEN_W + W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bram_read_scheduler_if #(.N_REQ(N_REQ), .ADDR_WIDTH(ADDR_WIDTH), .W(W),
                             .LEN_W(LEN_W), .ID_W(ID_W)) bus ();

    bram_read_scheduler #(.N_REQ(N_REQ), .ADDR_WIDTH(ADDR_WIDTH), .W(W),
                          .LEN_W(LEN_W), .RD_LAT(RD_LAT), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [W-1:0] data_of(input logic [ADDR_WIDTH-1:0] a);
        return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5A;
    endfunction

    // Two-cycle read latency BRAM preloaded with data_of(addr).
    logic [W-1:0] bram_p1;
    always @(posedge clk) begin
        bram_p1       <= bus.bram_ren ? data_of(bus.bram_addr) : 8'h00;
        bus.bram_dout <= bram_p1;
    end

    int vectors = 0, errors = 0;
    int cyc = 0, done_cnt = 0, ren_cnt = 0, grant_cyc = 0, cur_dly = 0;
    int hold_cnt [N_REQ];
    bit first_pending = 1'b0;
    logic [N_REQ-1:0] prev_g = '0, cur_g = '0;

    logic [ADDR_WIDTH-1:0] exp_addr_q [$];
    logic [BW-1:0]         exp_beat_q [$];
    logic [N_REQ-1:0]      exp_grant_q[$];
    int                    exp_dly_q  [$];
    int                    issue_q    [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input int base, input int len);
        bus.req_base[id*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(base);
        bus.req_len[id*LEN_W +: LEN_W]            = LEN_W'(len);
    endtask

    task automatic expect_burst(input int id, input int base, input int len);
        logic [ADDR_WIDTH-1:0] a;
        exp_grant_q.push_back(N_REQ'(1) << id);
        exp_dly_q.push_back(len == 0 ? 1 : len + RD_LAT + 2);
        for (int k = 0; k < len; k++) begin
            a = ADDR_WIDTH'(base + k);
            exp_addr_q.push_back(a);
            exp_beat_q.push_back({ID_W'(id), LEN_W'(k), data_of(a)});
        end
    endtask

    // One clock; sample #1 after the edge and check everything observable.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        chk("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
        if (bus.grant !== '0 && prev_g === '0) begin
            if (exp_grant_q.size() == 0) chk("grant_unexpected", 32'(bus.grant), 32'd0);
            else begin
                cur_g = exp_grant_q.pop_front();
                cur_dly = exp_dly_q.pop_front();
                chk("grant", 32'(bus.grant), 32'(cur_g));
                grant_cyc = cyc;
                first_pending = 1'b1;
            end
        end
        if (bus.bram_ren) begin
            ren_cnt++;
            chk("bram_en", 32'(bus.bram_en), 32'd1);
            if (first_pending) begin
                chk("first_issue_cycle", 32'(cyc), 32'(grant_cyc + 1));
                first_pending = 1'b0;
            end
            if (exp_addr_q.size() == 0) chk("ren_unexpected", 32'(bus.bram_ren), 32'd0);
            else begin
                chk("bram_addr", 32'(bus.bram_addr), 32'(exp_addr_q.pop_front()));
                issue_q.push_back(cyc);
            end
        end
        if (bus.rd_valid) begin
            if (exp_beat_q.size() == 0) chk("rd_unexpected", 32'(bus.rd_valid), 32'd0);
            else begin
                chk("beat", 32'({bus.rd_id, bus.rd_idx, bus.rd_data}), 32'(exp_beat_q.pop_front()));
                if (issue_q.size() > 0)
                    chk("beat_latency", 32'(cyc - issue_q.pop_front()), 32'(RD_LAT + 1));
            end
        end
        if (bus.done !== '0) begin
            done_cnt++;
            chk("done", 32'(bus.done), 32'(cur_g));
            chk("grant_at_done", 32'(bus.grant), 32'd0);
            chk("done_delay", 32'(cyc - grant_cyc), 32'(cur_dly));
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.done[i] && hold_cnt[i] > 0) begin
                    hold_cnt[i]--;
                    if (hold_cnt[i] == 0) bus.req[i] = 1'b0;
                end
            end
        end
        prev_g = bus.grant;
    endtask

    task automatic wait_dones(input int n, input int budget);
        int target = done_cnt + n;
        int b = 0;
        while (done_cnt < target && b < budget) begin
            step();
            b++;
        end
        chk("wait_done", 32'(done_cnt), 32'(target));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant"},    32'(bus.grant),     32'd0);
        chk({tag, "_done"},     32'(bus.done),      32'd0);
        chk({tag, "_busy"},     32'(bus.busy),      32'd0);
        chk({tag, "_en"},       32'(bus.bram_en),   32'd0);
        chk({tag, "_ren"},      32'(bus.bram_ren),  32'd0);
        chk({tag, "_addr"},     32'(bus.bram_addr), 32'd0);
        chk({tag, "_rd_valid"}, 32'(bus.rd_valid),  32'd0);
        chk({tag, "_rd_data"},  32'(bus.rd_data),   32'd0);
        chk({tag, "_rd_id"},    32'(bus.rd_id),     32'd0);
        chk({tag, "_rd_idx"},   32'(bus.rd_idx),    32'd0);
    endtask

    initial begin
        int r0, d0, b;
        bit seen;
        rst = 1'b1;
        bus.req = '0;
        bus.req_base = '0;
        bus.req_len = '0;
        for (int i = 0; i < N_REQ; i++) hold_cnt[i] = 0;
        repeat (3) step();
        chk_reset_outputs("reset");
        rst = 1'b0;
        step();

        // Single burst from requester 1 into the bias region.
        set_req(1, L12_BIAS_BASE, 8);
        expect_burst(1, L12_BIAS_BASE, 8);
        hold_cnt[1] = 1;
        bus.req[1] = 1'b1;
        wait_dones(1, 60);
        step();
        chk("busy_after_single", 32'(bus.busy), 32'd0);
        chk("done_single_pulse", 32'(bus.done), 32'd0);

        // Address wrap on requester 3; also returns the pointer to 0.
        set_req(3, 32766, 4);
        expect_burst(3, 32766, 4);
        hold_cnt[3] = 1;
        bus.req[3] = 1'b1;
        wait_dones(1, 60);

        // Contention 1011 from pointer 0; requester 0 keeps holding for a second burst.
        set_req(0, 'h100, 3);
        set_req(1, 'h200, 3);
        set_req(3, 'h300, 3);
        expect_burst(0, 'h100, 3);
        expect_burst(1, 'h200, 3);
        expect_burst(3, 'h300, 3);
        expect_burst(0, 'h100, 3);
        hold_cnt[0] = 2; hold_cnt[1] = 1; hold_cnt[3] = 1;
        bus.req = 4'b1011;
        wait_dones(4, 200);

        // Second round from pointer 1: order 1, 3, 0.
        expect_burst(1, 'h200, 3);
        expect_burst(3, 'h300, 3);
        expect_burst(0, 'h100, 3);
        hold_cnt[0] = 1; hold_cnt[1] = 1; hold_cnt[3] = 1;
        bus.req = 4'b1011;
        wait_dones(3, 150);

        // Zero-length burst.
        set_req(2, 'h50, 0);
        expect_burst(2, 'h50, 0);
        hold_cnt[2] = 1;
        r0 = ren_cnt;
        bus.req[2] = 1'b1;
        wait_dones(1, 20);
        chk("zero_len_no_ren", 32'(ren_cnt), 32'(r0));

        // Reset in the middle of a len=10 burst, right after beat 3.
        set_req(1, 'h40, 10);
        expect_burst(1, 'h40, 10);
        hold_cnt[1] = 1;
        bus.req[1] = 1'b1;
        seen = 1'b0;
        b = 0;
        while (!seen && b < 60) begin
            step();
            b++;
            if (bus.rd_valid && bus.rd_idx == LEN_W'(3)) seen = 1'b1;
        end
        chk("saw_beat3", 32'(seen), 32'd1);
        rst = 1'b1;
        bus.req = '0;
        d0 = done_cnt;
        step();
        chk_reset_outputs("mid_reset");
        repeat (4) step();
        chk("no_done_after_reset", 32'(done_cnt), 32'(d0));
        exp_addr_q.delete();
        exp_beat_q.delete();
        exp_grant_q.delete();
        exp_dly_q.delete();
        issue_q.delete();
        first_pending = 1'b0;
        for (int i = 0; i < N_REQ; i++) hold_cnt[i] = 0;
        rst = 1'b0;
        step();
        set_req(0, 'h10, 2);
        set_req(3, 'h20, 2);
        expect_burst(0, 'h10, 2);
        expect_burst(3, 'h20, 2);
        hold_cnt[0] = 1; hold_cnt[3] = 1;
        bus.req = 4'b1001;
        wait_dones(2, 80);

        // Requester 3 drops req after two addresses; burst must still complete.
        set_req(3, 'h600, 6);
        expect_burst(3, 'h600, 6);
        hold_cnt[3] = 0;
        bus.req[3] = 1'b1;
        r0 = ren_cnt;
        b = 0;
        while (ren_cnt - r0 < 2 && b < 20) begin
            step();
            b++;
        end
        bus.req[3] = 1'b0;
        wait_dones(1, 60);

        repeat (2) step();
        chk("final_busy", 32'(bus.busy), 32'd0);
        chk("left_addrs", 32'(exp_addr_q.size()), 32'd0);
        chk("left_beats", 32'(exp_beat_q.size()), 32'd0);
        chk("left_grants", 32'(exp_grant_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
